vga_frame_probe: RTL and testbench

//  VGA receive-side checker: samples the hsync/vsync/rgb stream produced by the game image generator and rebuilds pixel x/y from sync edges.
//  Per frame it reports the bounding box of pixels matching a target colour (e.g. the white ball), plus line count and timing errors.

---
 rtl/vga_frame_probe.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_vga_frame_probe.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_probe.sv
// vga_frame_probe: receive-side observer for a VGA hsync/vsync/rgb stream.
// Rebuilds pixel x/y from sync edges and, once per frame, publishes the bounding
// box of pixels whose colour equals TARGET, the line count and a timing-error flag.
//
// Optional feature macro: VGA_PROBE_CRC_EN adds frame_crc, a CRC-16-CCITT over the
// rgb bits of every visible pixel of the frame.
//
// Ports:
//   clk          system clock, same domain as the image generator
//   reset        synchronous, active-low reset
//   hsync/vsync  sync inputs (pulse level given by SYNC_POL)
//   rgb          3-bit pixel colour
//   box_x0/y0    min x/y of TARGET pixels in the last published frame
//   box_x1/y1    max x/y of TARGET pixels in the last published frame
//   found        at least one TARGET pixel in the last published frame
//   line_count   hsync pulse ends counted over the last frame period
//   frame_err    last frame had a line-count or line-length violation
//   frame_crc    (VGA_PROBE_CRC_EN only) CRC of the last frame's visible pixels
//   frame_valid  1-cycle strobe, outputs above updated in the same cycle
module vga_frame_probe #(
    parameter int unsigned PIX_DIV  = 2,
    parameter int unsigned H_VIS    = 640,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned H_TOTAL  = 800,
    parameter int unsigned V_VIS    = 480,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned V_TOTAL  = 525,
    parameter logic        SYNC_POL = 1'b0,
    parameter logic [2:0]  TARGET   = 3'b111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [2:0]  rgb,
    output logic [9:0]  box_x0,
    output logic [9:0]  box_y0,
    output logic [9:0]  box_x1,
    output logic [9:0]  box_y1,
    output logic        found,
    output logic [9:0]  line_count,
    output logic        frame_err,
`ifdef VGA_PROBE_CRC_EN
    output logic [15:0] frame_crc,
`endif
    output logic        frame_valid
);

    localparam int unsigned PdW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [PdW-1:0] PdLast = PdW'(PIX_DIV - 1);
    localparam logic [9:0] HVisLo = 10'(H_BP);
    localparam logic [9:0] HVisHi = 10'(H_BP + H_VIS);
    localparam logic [9:0] VVisLo = 10'(V_BP);
    localparam logic [9:0] VVisHi = 10'(V_BP + V_VIS);
    localparam logic [9:0] HTotal = 10'(H_TOTAL);
    localparam logic [9:0] VTotal = 10'(V_TOTAL);

    typedef enum logic [1:0] {StSeek, StAcq, StVsync} state_e;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

`ifdef VGA_PROBE_CRC_EN
    // Shift three data bits, MSB first, through CRC-16-CCITT (poly 0x1021).
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [2:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 2; i >= 0; i--) begin
            if (r[15] ^ d[i]) begin
                r = {r[14:0], 1'b0} ^ 16'h1021;
            end else begin
                r = {r[14:0], 1'b0};
            end
        end
        return r;
    endfunction
`endif

    // Input capture and edge-detect history
    logic       hs_q, hs_qq, vs_q, vs_qq;
    logic [2:0] rgb_q;

    // Front-end counters
    logic [PdW-1:0] pdiv_q, pdiv_d;
    logic [9:0]     hcnt_q, hcnt_d;
    logic [9:0]     vcnt_q, vcnt_d;
    logic [9:0]     lcnt_q, lcnt_d;
    logic           line_seen_q, line_seen_d;

    // Per-frame accumulators
    state_e     state_q, state_d;
    logic [9:0] min_x_q, min_x_d, min_y_q, min_y_d;
    logic [9:0] max_x_q, max_x_d, max_y_q, max_y_d;
    logic       hit_q, hit_d;
    logic       err_q, err_d;

    // Published outputs
    logic [9:0] box_x0_q, box_x0_d, box_y0_q, box_y0_d;
    logic [9:0] box_x1_q, box_x1_d, box_y1_q, box_y1_d;
    logic       found_q, found_d;
    logic [9:0] line_count_q, line_count_d;
    logic       frame_err_q, frame_err_d;
    logic       frame_valid_q, frame_valid_d;

`ifdef VGA_PROBE_CRC_EN
    logic [15:0] crc_q, crc_d;
    logic [15:0] frame_crc_q, frame_crc_d;
`endif

    logic       hs_act, hs_act_prev, vs_act, vs_act_prev;
    logic       hs_end, vs_start, vs_end;
    logic       sample, visible;
    logic [9:0] x, y;
    logic [9:0] lcnt_fin;

    assign hs_act      = (hs_q == SYNC_POL);
    assign hs_act_prev = (hs_qq == SYNC_POL);
    assign vs_act      = (vs_q == SYNC_POL);
    assign vs_act_prev = (vs_qq == SYNC_POL);
    assign hs_end      = hs_act_prev && !hs_act;
    assign vs_start    = !vs_act_prev && vs_act;
    assign vs_end      = vs_act_prev && !vs_act;

    // The hsync-end cycle is the first clock of pixel 0; its sample lands one clock later.
    assign sample  = (pdiv_q == '0) && !hs_end;
    assign x       = hcnt_q - HVisLo;
    assign y       = vcnt_q - VVisLo;
    assign visible = (hcnt_q >= HVisLo) && (hcnt_q < HVisHi) &&
                     (vcnt_q >= VVisLo) && (vcnt_q < VVisHi);

    // Line total spans vsync start to vsync start, so lines inside the vsync
    // pulse are included when compared against V_TOTAL.
    assign lcnt_fin = hs_end ? sat_inc(lcnt_q) : lcnt_q;

    always_comb begin
        pdiv_d        = pdiv_q;
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        lcnt_d        = lcnt_q;
        line_seen_d   = line_seen_q;
        state_d       = state_q;
        min_x_d       = min_x_q;
        min_y_d       = min_y_q;
        max_x_d       = max_x_q;
        max_y_d       = max_y_q;
        hit_d         = hit_q;
        err_d         = err_q;
        box_x0_d      = box_x0_q;
        box_y0_d      = box_y0_q;
        box_x1_d      = box_x1_q;
        box_y1_d      = box_y1_q;
        found_d       = found_q;
        line_count_d  = line_count_q;
        frame_err_d   = frame_err_q;
        frame_valid_d = 1'b0;
`ifdef VGA_PROBE_CRC_EN
        crc_d         = crc_q;
        frame_crc_d   = frame_crc_q;
`endif

        if (hs_end || pdiv_q == PdLast) begin
            pdiv_d = '0;
        end else begin
            pdiv_d = pdiv_q + PdW'(1);
        end

        if (hs_end) begin
            hcnt_d      = '0;
            line_seen_d = 1'b1;
        end else if (sample) begin
            hcnt_d = sat_inc(hcnt_q);
        end

        if (vs_end) begin
            vcnt_d = hs_end ? 10'd1 : 10'd0;
        end else if (hs_end) begin
            vcnt_d = sat_inc(vcnt_q);
        end

        if (vs_start) begin
            lcnt_d = hs_end ? 10'd1 : 10'd0;
        end else if (hs_end) begin
            lcnt_d = sat_inc(lcnt_q);
        end

        case (state_q)
            StSeek, StVsync: begin
                if (vs_end) begin
                    state_d = StAcq;
                    min_x_d = 10'h3FF;
                    min_y_d = 10'h3FF;
                    max_x_d = '0;
                    max_y_d = '0;
                    hit_d   = 1'b0;
                    err_d   = 1'b0;
`ifdef VGA_PROBE_CRC_EN
                    crc_d   = 16'hFFFF;
`endif
                end
            end
            StAcq: begin
                if (sample && visible) begin
                    if (rgb_q == TARGET) begin
                        hit_d = 1'b1;
                        if (x < min_x_q) min_x_d = x;
                        if (x > max_x_q) max_x_d = x;
                        if (y < min_y_q) min_y_d = y;
                        if (y > max_y_q) max_y_d = y;
                    end
`ifdef VGA_PROBE_CRC_EN
                    crc_d = crc_step(crc_q, rgb_q);
`endif
                end
                // A full line is one hsync end to the next; hcnt then holds its length.
                if (hs_end && line_seen_q && hcnt_q != HTotal) begin
                    err_d = 1'b1;
                end
                if (vs_start) begin
                    state_d       = StVsync;
                    frame_valid_d = 1'b1;
                    found_d       = hit_q;
                    box_x0_d      = hit_q ? min_x_q : 10'd0;
                    box_y0_d      = hit_q ? min_y_q : 10'd0;
                    box_x1_d      = hit_q ? max_x_q : 10'd0;
                    box_y1_d      = hit_q ? max_y_q : 10'd0;
                    line_count_d  = lcnt_fin;
                    frame_err_d   = err_q || (lcnt_fin != VTotal);
`ifdef VGA_PROBE_CRC_EN
                    frame_crc_d   = crc_q;
`endif
                end
            end
            default: state_d = StSeek;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            // Sync history resets to the idle level so release never fakes an edge.
            hs_q          <= ~SYNC_POL;
            hs_qq         <= ~SYNC_POL;
            vs_q          <= ~SYNC_POL;
            vs_qq         <= ~SYNC_POL;
            rgb_q         <= '0;
            pdiv_q        <= '0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            lcnt_q        <= '0;
            line_seen_q   <= 1'b0;
            state_q       <= StSeek;
            min_x_q       <= '0;
            min_y_q       <= '0;
            max_x_q       <= '0;
            max_y_q       <= '0;
            hit_q         <= 1'b0;
            err_q         <= 1'b0;
            box_x0_q      <= '0;
            box_y0_q      <= '0;
            box_x1_q      <= '0;
            box_y1_q      <= '0;
            found_q       <= 1'b0;
            line_count_q  <= '0;
            frame_err_q   <= 1'b0;
            frame_valid_q <= 1'b0;
`ifdef VGA_PROBE_CRC_EN
            crc_q         <= '0;
            frame_crc_q   <= '0;
`endif
        end else begin
            hs_q          <= hsync;
            hs_qq         <= hs_q;
            vs_q          <= vsync;
            vs_qq         <= vs_q;
            rgb_q         <= rgb;
            pdiv_q        <= pdiv_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            lcnt_q        <= lcnt_d;
            line_seen_q   <= line_seen_d;
            state_q       <= state_d;
            min_x_q       <= min_x_d;
            min_y_q       <= min_y_d;
            max_x_q       <= max_x_d;
            max_y_q       <= max_y_d;
            hit_q         <= hit_d;
            err_q         <= err_d;
            box_x0_q      <= box_x0_d;
            box_y0_q      <= box_y0_d;
            box_x1_q      <= box_x1_d;
            box_y1_q      <= box_y1_d;
            found_q       <= found_d;
            line_count_q  <= line_count_d;
            frame_err_q   <= frame_err_d;
            frame_valid_q <= frame_valid_d;
`ifdef VGA_PROBE_CRC_EN
            crc_q         <= crc_d;
            frame_crc_q   <= frame_crc_d;
`endif
        end
    end

    assign box_x0      = box_x0_q;
    assign box_y0      = box_y0_q;
    assign box_x1      = box_x1_q;
    assign box_y1      = box_y1_q;
    assign found       = found_q;
    assign line_count  = line_count_q;
    assign frame_err   = frame_err_q;
    assign frame_valid = frame_valid_q;
`ifdef VGA_PROBE_CRC_EN
    assign frame_crc   = frame_crc_q;
`endif

endmodule

// File: tb/tb_vga_frame_probe.sv
// Bench for vga_frame_probe using a scaled-down raster (16x12 visible, 24x18 total,
// 2 clocks per pixel) so that many whole frames fit in a short run.
// Raster: h 0..15 visible, 16..17 front porch, 18..20 hsync, 21..23 back porch;
//         v 0..11 visible, 12 front porch, 13..14 vsync, 15..17 back porch.
module tb_vga_frame_probe;

    localparam int unsigned PixDiv = 2;
    localparam int unsigned HVis   = 16;
    localparam int unsigned HBp    = 3;
    localparam int unsigned HTot   = 24;
    localparam int unsigned VVis   = 12;
    localparam int unsigned VBp    = 3;
    localparam int unsigned VTot   = 18;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       hsync, vsync;
    logic [2:0] rgb;
    logic [9:0] box_x0, box_y0, box_x1, box_y1, line_count;
    logic       found, frame_err, frame_valid;
`ifdef VGA_PROBE_CRC_EN
    logic [15:0] frame_crc;
    logic [15:0] cap_crc;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int fv_count = 0;
    int fv_cyc   = 0;
    int vs_start_cyc = 0;
    logic [9:0] cap_x0, cap_y0, cap_x1, cap_y1, cap_lines;
    logic       cap_found, cap_err;

    vga_frame_probe #(
        .PIX_DIV (PixDiv),
        .H_VIS   (HVis),
        .H_BP    (HBp),
        .H_TOTAL (HTot),
        .V_VIS   (VVis),
        .V_BP    (VBp),
        .V_TOTAL (VTot),
        .SYNC_POL(1'b0),
        .TARGET  (3'b111)
    ) dut (
        .clk        (clk),
        .reset      (reset_n),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb        (rgb),
        .box_x0     (box_x0),
        .box_y0     (box_y0),
        .box_x1     (box_x1),
        .box_y1     (box_y1),
        .found      (found),
        .line_count (line_count),
        .frame_err  (frame_err),
`ifdef VGA_PROBE_CRC_EN
        .frame_crc  (frame_crc),
`endif
        .frame_valid(frame_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture the published values in the strobe cycle, away from the active edge.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            fv_count  = fv_count + 1;
            fv_cyc    = cyc;
            cap_x0    = box_x0;
            cap_y0    = box_y0;
            cap_x1    = box_x1;
            cap_y1    = box_y1;
            cap_found = found;
            cap_lines = line_count;
            cap_err   = frame_err;
`ifdef VGA_PROBE_CRC_EN
            cap_crc   = frame_crc;
`endif
        end
    end

    // Image modes: 0 black, 1 white square x4..7 y2..5, 2 white corners, 3 one green pixel.
    function automatic logic [2:0] pix(input int mode, input int x, input int y);
        case (mode)
            1: return (x >= 4 && x <= 7 && y >= 2 && y <= 5) ? 3'b111 : 3'b000;
            2: return ((x == 0 && y == 0) || (x == 15 && y == 11)) ? 3'b111 : 3'b000;
            3: return (x == 5 && y == 5) ? 3'b010 : 3'b000;
            default: return 3'b000;
        endcase
    endfunction

`ifdef VGA_PROBE_CRC_EN
    function automatic logic [15:0] crc_model(input int mode);
        logic [15:0] c;
        logic [2:0]  p;
        logic        fb;
        c = 16'hFFFF;
        for (int y = 0; y < int'(VVis); y++) begin
            for (int x = 0; x < int'(HVis); x++) begin
                p = pix(mode, x, y);
                for (int b = 2; b >= 0; b--) begin
                    fb = c[15] ^ p[b];
                    c  = {c[14:0], 1'b0};
                    if (fb) c = c ^ 16'h1021;
                end
            end
        end
        return c;
    endfunction
`endif

    // One whole raster frame; optionally drops the hsync pulse of skip_line and
    // pulses reset low for 3 clocks at the start of rst_line.
    task automatic run_frame(input int mode, input int skip_line, input int rst_line);
        int rst_left;
        rst_left = 0;
        for (int v = 0; v < int'(VTot); v++) begin
            for (int h = 0; h < int'(HTot); h++) begin
                for (int c = 0; c < int'(PixDiv); c++) begin
                    if (v == rst_line && h == 0 && c == 0) rst_left = 3;
                    reset_n = (rst_left > 0) ? 1'b0 : 1'b1;
                    if (rst_left > 0) rst_left--;
                    hsync = (h >= 18 && h <= 20 && v != skip_line) ? 1'b0 : 1'b1;
                    vsync = (v >= 13 && v <= 14) ? 1'b0 : 1'b1;
                    rgb   = (v < int'(VVis) && h < int'(HVis)) ? pix(mode, h, v) : 3'b000;
                    if (v == 13 && h == 0 && c == 0) vs_start_cyc = cyc;
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        hsync   = 1'b1;
        vsync   = 1'b1;
        rgb     = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (frame_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_frame_valid: got %b expected 0", frame_valid);
        end
        n_tests++;
        if ({box_x0, box_y0, box_x1, box_y1} !== 40'd0) begin
            n_fail++; $display("FAIL reset_box: got (%0d,%0d)-(%0d,%0d) expected all 0",
                               box_x0, box_y0, box_x1, box_y1);
        end
        n_tests++;
        if ({found, frame_err, line_count} !== 12'd0) begin
            n_fail++; $display("FAIL reset_flags: got found=%b err=%b lines=%0d expected 0",
                               found, frame_err, line_count);
        end
    endtask

    task automatic test_square;
        int base;
        base = fv_count;
        run_frame(1, -1, -1);
        n_tests++;
        if (fv_count - base != 0) begin
            n_fail++; $display("FAIL seek_no_publish: got %0d strobes expected 0", fv_count - base);
        end
        base = fv_count;
        run_frame(1, -1, -1);
        n_tests++;
        if (fv_count - base != 1) begin
            n_fail++; $display("FAIL square_strobes: got %0d expected 1", fv_count - base);
        end
        n_tests++;
        if (fv_cyc - vs_start_cyc != 2) begin
            n_fail++; $display("FAIL square_latency: got %0d clk expected 2", fv_cyc - vs_start_cyc);
        end
        n_tests++;
        if ({cap_x0, cap_y0, cap_x1, cap_y1} !== {10'd4, 10'd2, 10'd7, 10'd5}) begin
            n_fail++; $display("FAIL square_box: got (%0d,%0d)-(%0d,%0d) expected (4,2)-(7,5)",
                               cap_x0, cap_y0, cap_x1, cap_y1);
        end
        n_tests++;
        if (cap_found !== 1'b1 || cap_lines !== 10'd18 || cap_err !== 1'b0) begin
            n_fail++; $display("FAIL square_stats: got found=%b lines=%0d err=%b expected 1/18/0",
                               cap_found, cap_lines, cap_err);
        end
        // Outputs hold after the strobe
        n_tests++;
        if (box_x1 !== 10'd7 || found !== 1'b1) begin
            n_fail++; $display("FAIL square_hold: got x1=%0d found=%b expected 7/1", box_x1, found);
        end
    endtask

    task automatic test_black;
        int base;
        base = fv_count;
        run_frame(0, -1, -1);
        n_tests++;
        if (fv_count - base != 1) begin
            n_fail++; $display("FAIL black_strobes: got %0d expected 1", fv_count - base);
        end
        n_tests++;
        if ({cap_x0, cap_y0, cap_x1, cap_y1} !== 40'd0 || cap_found !== 1'b0) begin
            n_fail++; $display("FAIL black_box: got (%0d,%0d)-(%0d,%0d) found=%b expected 0s",
                               cap_x0, cap_y0, cap_x1, cap_y1, cap_found);
        end
        n_tests++;
        if (cap_err !== 1'b0 || cap_lines !== 10'd18) begin
            n_fail++; $display("FAIL black_timing: got err=%b lines=%0d expected 0/18",
                               cap_err, cap_lines);
        end
    endtask

    task automatic test_corners;
        run_frame(2, -1, -1);
        n_tests++;
        if ({cap_x0, cap_y0, cap_x1, cap_y1} !== {10'd0, 10'd0, 10'd15, 10'd11} ||
            cap_found !== 1'b1) begin
            n_fail++; $display("FAIL corners_box: got (%0d,%0d)-(%0d,%0d) found=%b expected (0,0)-(15,11) 1",
                               cap_x0, cap_y0, cap_x1, cap_y1, cap_found);
        end
    endtask

    task automatic test_non_target;
        run_frame(3, -1, -1);
        n_tests++;
        if (cap_found !== 1'b0 || cap_x1 !== 10'd0) begin
            n_fail++; $display("FAIL non_target: got found=%b x1=%0d expected 0/0", cap_found, cap_x1);
        end
    endtask

    task automatic test_missing_hsync;
        run_frame(0, 4, -1);
        n_tests++;
        if (cap_lines !== 10'd17 || cap_err !== 1'b1) begin
            n_fail++; $display("FAIL missing_hsync: got lines=%0d err=%b expected 17/1",
                               cap_lines, cap_err);
        end
        run_frame(0, -1, -1);
        n_tests++;
        if (cap_lines !== 10'd18 || cap_err !== 1'b0) begin
            n_fail++; $display("FAIL recover_clean: got lines=%0d err=%b expected 18/0",
                               cap_lines, cap_err);
        end
    endtask

    task automatic test_reset_mid;
        int base;
        run_frame(1, -1, -1);
        base = fv_count;
        run_frame(1, -1, 5);
        n_tests++;
        if (fv_count - base != 0) begin
            n_fail++; $display("FAIL midreset_no_publish: got %0d strobes expected 0", fv_count - base);
        end
        n_tests++;
        if ({box_x0, box_y0, box_x1, box_y1, line_count} !== 50'd0 || found !== 1'b0) begin
            n_fail++; $display("FAIL midreset_outputs: got (%0d,%0d)-(%0d,%0d) lines=%0d found=%b expected 0s",
                               box_x0, box_y0, box_x1, box_y1, line_count, found);
        end
        base = fv_count;
        run_frame(2, -1, -1);
        n_tests++;
        if (fv_count - base != 1 || cap_x1 !== 10'd15 || cap_y1 !== 10'd11 ||
            cap_lines !== 10'd18 || cap_err !== 1'b0) begin
            n_fail++; $display("FAIL midreset_first_frame: got strobes=%0d x1=%0d y1=%0d lines=%0d err=%b expected 1/15/11/18/0",
                               fv_count - base, cap_x1, cap_y1, cap_lines, cap_err);
        end
    endtask

`ifdef VGA_PROBE_CRC_EN
    task automatic test_crc;
        logic [15:0] crc_a, crc_b;
        run_frame(0, -1, -1);
        crc_a = cap_crc;
        run_frame(0, -1, -1);
        crc_b = cap_crc;
        n_tests++;
        if (crc_a !== crc_b || crc_a !== crc_model(0)) begin
            n_fail++; $display("FAIL crc_black: got %h/%h expected %h", crc_a, crc_b, crc_model(0));
        end
        run_frame(3, -1, -1);
        n_tests++;
        if (cap_crc === crc_a || cap_crc !== crc_model(3)) begin
            n_fail++; $display("FAIL crc_pixel: got %h expected %h (black %h)",
                               cap_crc, crc_model(3), crc_a);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_square();
        test_black();
        test_corners();
        test_non_target();
        test_missing_hsync();
        test_reset_mid();
`ifdef VGA_PROBE_CRC_EN
        test_crc();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
